// File: rtl/add_seq_pkg.sv
// Shared types and constants for the multi-cycle add/subtract unit.
// Holds the FSM state encoding, default geometry and op encoding.
package add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add_seq_if.sv
// Request/result handshake bundle for add_seq; slave is the adder, master the requester.
// Requests handshake on in_valid/in_ready; results on out_valid/out_ready.
interface add_seq_if
    import add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    logic             busy;

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow, busy
    );

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow, busy
    );

endinterface

// File: rtl/add_seq_slice.sv
// Combinational SLICE-bit carry-lookahead adder: zero latency, no backpressure.
// Each carry is a flat OR of generate/propagate product terms, no ripple chain.
module add4_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    logic [SLICE-1:0] w_g;
    logic [SLICE-1:0] w_p;
    logic [SLICE:0]   w_c;
    logic             w_prod;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // c[i+1] = cin&p[i:0] | OR over k of g[k]&p[i:k+1]
    always_comb begin
        w_c    = '0;
        w_prod = 1'b0;
        w_c[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            w_prod = cin;
            for (int k = 0; k <= i; k++) begin
                w_prod = w_prod & w_p[k];
            end
            w_c[i+1] = w_prod;
            for (int k = 0; k <= i; k++) begin
                w_prod = w_g[k];
                for (int m = k + 1; m <= i; m++) begin
                    w_prod = w_prod & w_p[m];
                end
                w_c[i+1] = w_c[i+1] | w_prod;
            end
        end
    end

    assign sum  = w_p ^ w_c[SLICE-1:0];
    assign cout = w_c[SLICE];

endmodule

// File: rtl/add_seq.sv
// Multi-cycle add/subtract, one SLICE-bit lookahead slice per cycle; result valid WIDTH/SLICE cycles after accept.
// Result holds in DONE until out_ready; no new request is taken until the cycle after that handshake.
module add_seq
    import add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic      clk,
    input  logic      rst,
    add_seq_if.slave  bus
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    state_t                        r_state;
    logic [CNT_W-1:0]              r_cnt;
    logic [NSLICE-1:0][SLICE-1:0]  r_a;
    logic [NSLICE-1:0][SLICE-1:0]  r_b;
    logic [NSLICE-1:0][SLICE-1:0]  r_sum;
    logic                          r_carry;
    logic                          r_cout;
    logic                          r_ovf;
    logic                          r_busy;

    logic [SLICE-1:0]              w_slice_a;
    logic [SLICE-1:0]              w_slice_b;
    logic [SLICE-1:0]              w_slice_sum;
    logic                          w_slice_cout;

    assign w_slice_a = r_a[r_cnt];
    assign w_slice_b = r_b[r_cnt];

    add4_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a    (w_slice_a),
        .b    (w_slice_b),
        .cin  (r_carry),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Subtract is A + ~B + 1: the +1 enters as the initial carry.
                        r_a     <= bus.a;
                        r_b     <= (bus.sub == OP_SUB) ? ~bus.b : bus.b;
                        r_carry <= bus.sub;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sum[r_cnt] <= w_slice_sum;
                    r_carry      <= w_slice_cout;
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_cout  <= w_slice_cout;
                        r_ovf   <= (r_a[NSLICE-1][SLICE-1] == r_b[NSLICE-1][SLICE-1]) &&
                                   (w_slice_sum[SLICE-1] != r_a[NSLICE-1][SLICE-1]);
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // in_ready is gated by rst so it reads 0 during the reset cycle itself.
    assign bus.in_ready  = (r_state == IDLE) && !rst;
    assign bus.out_valid = (r_state == DONE);
    assign bus.sum       = r_sum;
    assign bus.carry_out = r_cout;
    assign bus.overflow  = r_ovf;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_add_seq.sv
// Self-checking bench for add_seq: directed vectors, backpressure, reset mid-op, throughput, random ops.
// Expected results come from plain integer arithmetic on the operands.
module tb_add_seq;
    import add_pkg::*;

    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    add_seq_if #(.WIDTH(32)) bus ();

    add_seq #(.WIDTH(32), .SLICE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic void ref_model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                      output logic [31:0] sum, output logic c, output logic v);
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint r;
        if (s) begin
            sum = a - b;
            c   = (ua >= ub);
            r   = sa - sb;
        end else begin
            sum = a + b;
            c   = ((ua + ub) >> 32) != 0;
            r   = sa + sb;
        end
        v = (r > MAXS) || (r < MINS);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request and return cycles from accept to out_valid (-1 on timeout).
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, output int lat);
        int g = 0;
        lat = -1;
        while (!bus.in_ready && g < 40) begin
            tick();
            g++;
        end
        if (!bus.in_ready) return;
        bus.a = a;
        bus.b = b;
        bus.sub = s;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        bus.sub = 1'($urandom_range(0, 1));
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!bus.out_valid) lat = -1;
    endtask

    task automatic take_result();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready_first got=%b exp=0", bus.in_ready); end
        tick();
        tick();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        total++; if (bus.sum !== 32'd0) begin bad++; $display("FAIL rst_sum got=%h exp=0", bus.sum); end
        total++; if (bus.carry_out !== 1'b0) begin bad++; $display("FAIL rst_carry got=%b exp=0", bus.carry_out); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", bus.overflow); end
        rst = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_directed();
        logic [31:0] ta[4] = '{32'h00000001, 32'h7FFFFFFF, 32'h00000005, 32'h80000000};
        logic [31:0] tb[4] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000007, 32'h00000001};
        logic        ts[4] = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB};
        logic [31:0] es[4] = '{32'h00000000, 32'h80000000, 32'hFFFFFFFE, 32'h7FFFFFFF};
        logic        ec[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic        ev[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 4; i++) begin
            send(ta[i], tb[i], ts[i], lat);
            total++; if (lat !== 8) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=8", i, lat); end
            total++; if (bus.sum !== es[i]) begin bad++; $display("FAIL dir%0d_sum got=%h exp=%h", i, bus.sum, es[i]); end
            total++; if (bus.carry_out !== ec[i]) begin bad++; $display("FAIL dir%0d_carry got=%b exp=%b", i, bus.carry_out, ec[i]); end
            total++; if (bus.overflow !== ev[i]) begin bad++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, bus.overflow, ev[i]); end
            take_result();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] es;
        logic        ec;
        logic        ev;
        int lat;
        ref_model(32'hFFFF0000, 32'h0001FFFF, OP_ADD, es, ec, ev);
        send(32'hFFFF0000, 32'h0001FFFF, OP_ADD, lat);
        total++; if (lat !== 8) begin bad++; $display("FAIL bp_latency got=%0d exp=8", lat); end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid cyc%0d got=%b exp=1", i, bus.out_valid); end
            total++; if (bus.sum !== es) begin bad++; $display("FAIL bp_hold_sum cyc%0d got=%h exp=%h", i, bus.sum, es); end
            total++; if (bus.carry_out !== ec) begin bad++; $display("FAIL bp_hold_carry cyc%0d got=%b exp=%b", i, bus.carry_out, ec); end
            total++; if (bus.overflow !== ev) begin bad++; $display("FAIL bp_hold_ovf cyc%0d got=%b exp=%b", i, bus.overflow, ev); end
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_in_ready cyc%0d got=%b exp=0", i, bus.in_ready); end
        end
        // A request offered during the result handshake must not be taken on that edge.
        bus.in_valid = 1'b1;
        bus.a = 32'h1;
        bus.b = 32'h1;
        bus.sub = OP_ADD;
        take_result();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready_after got=%b exp=1", bus.in_ready); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL bp_no_accept_on_handshake busy got=%b exp=0", bus.busy); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_out_valid_after got=%b exp=0", bus.out_valid); end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_ignore_during_run();
        logic [31:0] a1 = $urandom;
        logic [31:0] b1 = $urandom;
        logic        s1 = 1'($urandom_range(0, 1));
        logic [31:0] es;
        logic        ec;
        logic        ev;
        int lat = 0;
        ref_model(a1, b1, s1, es, ec, ev);
        bus.a = a1;
        bus.b = b1;
        bus.sub = s1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        lat = 2;
        bus.a = ~a1;
        bus.b = a1 ^ b1;
        bus.sub = ~s1;
        bus.in_valid = 1'b1;
        tick();
        lat++;
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        total++; if (lat !== 8) begin bad++; $display("FAIL ign_latency got=%0d exp=8", lat); end
        total++; if (bus.sum !== es) begin bad++; $display("FAIL ign_sum got=%h exp=%h", bus.sum, es); end
        total++; if (bus.carry_out !== ec) begin bad++; $display("FAIL ign_carry got=%b exp=%b", bus.carry_out, ec); end
        total++; if (bus.overflow !== ev) begin bad++; $display("FAIL ign_ovf got=%b exp=%b", bus.overflow, ev); end
        take_result();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ign_no_second_op busy got=%b exp=0", bus.busy); end
        tick();
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ign_no_second_result got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        int lat;
        bus.a = 32'hDEADBEEF;
        bus.b = 32'hFFFFFFFF;
        bus.sub = OP_ADD;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
        total++; if (bus.sum !== 32'd0) begin bad++; $display("FAIL midrst_sum got=%h exp=0", bus.sum); end
        total++; if (bus.carry_out !== 1'b0) begin bad++; $display("FAIL midrst_carry got=%b exp=0", bus.carry_out); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL midrst_ovf got=%b exp=0", bus.overflow); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b exp=1", bus.in_ready); end
        for (int i = 0; i < 10; i++) tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_result got=%b exp=0", bus.out_valid); end
        send(32'h12345678, 32'h11111111, OP_ADD, lat);
        total++; if (lat !== 8) begin bad++; $display("FAIL midrst_next_latency got=%0d exp=8", lat); end
        total++; if (bus.sum !== 32'h23456789) begin bad++; $display("FAIL midrst_next_sum got=%h exp=23456789", bus.sum); end
        total++; if (bus.carry_out !== 1'b0) begin bad++; $display("FAIL midrst_next_carry got=%b exp=0", bus.carry_out); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL midrst_next_ovf got=%b exp=0", bus.overflow); end
        take_result();
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int edge_n = 0;
        logic will_accept;
        int g = 0;
        bus.out_ready = 1'b1;
        bus.a = 32'h00000001;
        bus.b = 32'h00000002;
        bus.sub = OP_ADD;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            will_accept = bus.in_ready && bus.in_valid;
            tick();
            edge_n++;
            if (will_accept) acc.push_back(edge_n);
        end
        bus.in_valid = 1'b0;
        total++;
        if (acc.size() < 3) begin
            bad++;
            $display("FAIL b2b_accept_count got=%0d exp>=3", acc.size());
        end else begin
            total++; if (acc[1] - acc[0] !== 10) begin bad++; $display("FAIL b2b_ii_0 got=%0d exp=10", acc[1] - acc[0]); end
            total++; if (acc[2] - acc[1] !== 10) begin bad++; $display("FAIL b2b_ii_1 got=%0d exp=10", acc[2] - acc[1]); end
        end
        while (!bus.in_ready && g < 40) begin
            tick();
            g++;
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] es;
        logic        ec;
        logic        ev;
        int lat;
        int d;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            if (i % 6 == 1) b = 32'h80000000;
            if (i % 6 == 4) a = b;
            ref_model(a, b, s, es, ec, ev);
            send(a, b, s, lat);
            total++; if (lat !== 8) begin bad++; $display("FAIL rnd%0d_latency got=%0d exp=8", i, lat); end
            d = $urandom_range(0, 3);
            for (int k = 0; k < d; k++) tick();
            total++; if (bus.sum !== es) begin bad++; $display("FAIL rnd%0d_sum a=%h b=%h sub=%b got=%h exp=%h", i, a, b, s, bus.sum, es); end
            total++; if (bus.carry_out !== ec) begin bad++; $display("FAIL rnd%0d_carry got=%b exp=%b", i, bus.carry_out, ec); end
            total++; if (bus.overflow !== ev) begin bad++; $display("FAIL rnd%0d_ovf got=%b exp=%b", i, bus.overflow, ev); end
            take_result();
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.sub = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_ignore_during_run();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
